// File: rtl/forwarding_control_if.sv
//==============================================================================
// Module      : forwarding_control_if
// Description : Hazard-compare inputs and forwarding select/counter outputs
//               of the EX-stage forwarding unit.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface forwarding_control_if #(
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
);
    logic              i_rd_wren_mem;
    logic              i_rd_wren_wb;
    logic [ADDR_W-1:0] i_rs1_addr;
    logic [ADDR_W-1:0] i_rs2_addr;
    logic [ADDR_W-1:0] i_mem_rd_addr;
    logic [ADDR_W-1:0] i_wb_rd_addr;
    logic [1:0]        o_forwarding_a;
    logic [1:0]        o_forwarding_b;
    logic [CNT_W-1:0]  o_fwd_mem_cnt;
    logic [CNT_W-1:0]  o_fwd_wb_cnt;

    modport master (
        output i_rd_wren_mem, i_rd_wren_wb, i_rs1_addr, i_rs2_addr,
               i_mem_rd_addr, i_wb_rd_addr,
        input  o_forwarding_a, o_forwarding_b, o_fwd_mem_cnt, o_fwd_wb_cnt
    );

    modport slave (
        input  i_rd_wren_mem, i_rd_wren_wb, i_rs1_addr, i_rs2_addr,
               i_mem_rd_addr, i_wb_rd_addr,
        output o_forwarding_a, o_forwarding_b, o_fwd_mem_cnt, o_fwd_wb_cnt
    );
endinterface

`default_nettype wire

// File: rtl/forwarding_control.sv
//==============================================================================
// Module      : forwarding_control
// Description : EX-stage data-hazard forwarding unit with saturating
//               forwarding-event counters.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module forwarding_control #(
    parameter int ADDR_W  = 5,
    parameter int CNT_W   = 16,
    parameter int REG_OUT = 0
) (
    input  wire logic            i_clk,
    input  wire logic            i_rst_n,
    forwarding_control_if.slave  bus
);

    localparam logic [ADDR_W-1:0] X0_ADDR  = '0;
    localparam logic [1:0]        SEL_REG  = 2'b00;
    localparam logic [1:0]        SEL_MEM  = 2'b10;
    localparam logic [1:0]        SEL_WB   = 2'b01;
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    logic             mem_hit_a;
    logic             mem_hit_b;
    logic             wb_hit_a;
    logic             wb_hit_b;
    logic [1:0]       sel_a;
    logic [1:0]       sel_b;
    logic             mem_event;
    logic             wb_event;
    logic [CNT_W-1:0] mem_cnt;
    logic [CNT_W-1:0] wb_cnt;

    // x0 is hard-wired to zero, so a write to it must never be forwarded.
    assign mem_hit_a = bus.i_rd_wren_mem && (bus.i_mem_rd_addr == bus.i_rs1_addr)
                       && (bus.i_mem_rd_addr != X0_ADDR);
    assign mem_hit_b = bus.i_rd_wren_mem && (bus.i_mem_rd_addr == bus.i_rs2_addr)
                       && (bus.i_mem_rd_addr != X0_ADDR);
    assign wb_hit_a  = bus.i_rd_wren_wb && (bus.i_wb_rd_addr == bus.i_rs1_addr)
                       && (bus.i_wb_rd_addr != X0_ADDR);
    assign wb_hit_b  = bus.i_rd_wren_wb && (bus.i_wb_rd_addr == bus.i_rs2_addr)
                       && (bus.i_wb_rd_addr != X0_ADDR);

    always_comb begin
        sel_a = SEL_REG;
        sel_b = SEL_REG;
        if (mem_hit_a)     sel_a = SEL_MEM;
        else if (wb_hit_a) sel_a = SEL_WB;
        if (mem_hit_b)     sel_b = SEL_MEM;
        else if (wb_hit_b) sel_b = SEL_WB;
    end

    // Counter conditions always use the combinational selects, even when
    // the outputs are registered.
    assign mem_event = (sel_a == SEL_MEM) || (sel_b == SEL_MEM);
    assign wb_event  = ((sel_a == SEL_WB) || (sel_b == SEL_WB)) && !mem_event;

    generate
        if (REG_OUT != 0) begin : g_reg_out
            logic [1:0] sel_a_q;
            logic [1:0] sel_b_q;

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    sel_a_q <= SEL_REG;
                    sel_b_q <= SEL_REG;
                end else begin
                    sel_a_q <= sel_a;
                    sel_b_q <= sel_b;
                end
            end

            assign bus.o_forwarding_a = sel_a_q;
            assign bus.o_forwarding_b = sel_b_q;
        end else begin : g_comb_out
            assign bus.o_forwarding_a = sel_a;
            assign bus.o_forwarding_b = sel_b;
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mem_cnt <= '0;
            wb_cnt  <= '0;
        end else begin
            if (mem_event && (mem_cnt != CNT_MAX)) mem_cnt <= mem_cnt + 1'b1;
            if (wb_event  && (wb_cnt  != CNT_MAX)) wb_cnt  <= wb_cnt + 1'b1;
        end
    end

    assign bus.o_fwd_mem_cnt = mem_cnt;
    assign bus.o_fwd_wb_cnt  = wb_cnt;

endmodule

`default_nettype wire

// File: tb/tb_forwarding_control.sv
//==============================================================================
// Module      : tb_forwarding_control
// Description : Directed vector bench for forwarding_control, combinational
//               and registered-select variants.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_forwarding_control;

    logic i_clk;
    logic i_rst_n;
    int   tests;
    int   fails;

    forwarding_control_if #(.ADDR_W(5), .CNT_W(16)) bus_c ();
    forwarding_control_if #(.ADDR_W(5), .CNT_W(3))  bus_r ();

    forwarding_control #(.ADDR_W(5), .CNT_W(16), .REG_OUT(0)) dut_c (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus_c.slave)
    );

    forwarding_control #(.ADDR_W(5), .CNT_W(3), .REG_OUT(1)) dut_r (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus_r.slave)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic       wm;
        logic       ww;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] mrd;
        logic [4:0] wrd;
        logic [1:0] ea;
        logic [1:0] eb;
    } vec_t;

    vec_t vecs [12];

    task automatic drive(input logic wm, input logic ww, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] mrd,
                         input logic [4:0] wrd);
        bus_c.i_rd_wren_mem = wm;  bus_r.i_rd_wren_mem = wm;
        bus_c.i_rd_wren_wb  = ww;  bus_r.i_rd_wren_wb  = ww;
        bus_c.i_rs1_addr    = rs1; bus_r.i_rs1_addr    = rs1;
        bus_c.i_rs2_addr    = rs2; bus_r.i_rs2_addr    = rs2;
        bus_c.i_mem_rd_addr = mrd; bus_r.i_mem_rd_addr = mrd;
        bus_c.i_wb_rd_addr  = wrd; bus_r.i_wb_rd_addr  = wrd;
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;

        vecs[0]  = '{1'b0, 1'b0, 5'd1,  5'd2, 5'd3,  5'd4, 2'b00, 2'b00};
        vecs[1]  = '{1'b1, 1'b0, 5'd3,  5'd2, 5'd3,  5'd4, 2'b10, 2'b00};
        vecs[2]  = '{1'b1, 1'b0, 5'd1,  5'd3, 5'd3,  5'd4, 2'b00, 2'b10};
        vecs[3]  = '{1'b0, 1'b1, 5'd4,  5'd2, 5'd3,  5'd4, 2'b01, 2'b00};
        vecs[4]  = '{1'b0, 1'b1, 5'd1,  5'd4, 5'd3,  5'd4, 2'b00, 2'b01};
        vecs[5]  = '{1'b1, 1'b1, 5'd3,  5'd4, 5'd3,  5'd4, 2'b10, 2'b01};
        vecs[6]  = '{1'b1, 1'b1, 5'd3,  5'd3, 5'd3,  5'd3, 2'b10, 2'b10};
        vecs[7]  = '{1'b1, 1'b0, 5'd0,  5'd2, 5'd0,  5'd4, 2'b00, 2'b00};
        vecs[8]  = '{1'b0, 1'b1, 5'd0,  5'd0, 5'd3,  5'd0, 2'b00, 2'b00};
        vecs[9]  = '{1'b1, 1'b1, 5'd5,  5'd5, 5'd7,  5'd5, 2'b01, 2'b01};
        vecs[10] = '{1'b0, 1'b1, 5'd3,  5'd4, 5'd3,  5'd4, 2'b00, 2'b01};
        vecs[11] = '{1'b1, 1'b1, 5'd31, 5'd0, 5'd31, 5'd0, 2'b10, 2'b00};

        // Reset state
        i_rst_n = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
        #1;
        check("rst_mem_cnt_c", 32'(bus_c.o_fwd_mem_cnt), 32'd0);
        check("rst_wb_cnt_c",  32'(bus_c.o_fwd_wb_cnt),  32'd0);
        check("rst_mem_cnt_r", 32'(bus_r.o_fwd_mem_cnt), 32'd0);

        // Combinational selects ignore reset; registered ones stay 00.
        drive(1'b1, 1'b0, 5'd3, 5'd2, 5'd3, 5'd4);
        @(posedge i_clk); #1;
        check("rst_comb_sel_a", 32'(bus_c.o_forwarding_a), 32'h2);
        check("rst_reg_sel_a",  32'(bus_r.o_forwarding_a), 32'h0);
        check("rst_cnt_hold",   32'(bus_c.o_fwd_mem_cnt),  32'd0);

        @(negedge i_clk);
        i_rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            @(negedge i_clk);
            drive(vecs[i].wm, vecs[i].ww, vecs[i].rs1, vecs[i].rs2,
                  vecs[i].mrd, vecs[i].wrd);
            #1;
            check($sformatf("vec%0d_comb_a", i), 32'(bus_c.o_forwarding_a), 32'(vecs[i].ea));
            check($sformatf("vec%0d_comb_b", i), 32'(bus_c.o_forwarding_b), 32'(vecs[i].eb));
            @(posedge i_clk); #1;
            check($sformatf("vec%0d_reg_a", i), 32'(bus_r.o_forwarding_a), 32'(vecs[i].ea));
            check($sformatf("vec%0d_reg_b", i), 32'(bus_r.o_forwarding_b), 32'(vecs[i].eb));
        end

        // Clear counters, then hold a MEM hit for 5 clocks
        @(negedge i_clk);
        i_rst_n = 1'b0;
        drive(1'b1, 1'b0, 5'd3, 5'd2, 5'd3, 5'd4);
        #1;
        check("clr_mem_cnt", 32'(bus_c.o_fwd_mem_cnt), 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (5) @(posedge i_clk);
        #1;
        check("mem5_mem_cnt", 32'(bus_c.o_fwd_mem_cnt), 32'd5);
        check("mem5_wb_cnt",  32'(bus_c.o_fwd_wb_cnt),  32'd0);
        check("mem5_mem_cnt_r", 32'(bus_r.o_fwd_mem_cnt), 32'd5);

        // Mid-cycle reset pulse clears immediately
        #2;
        i_rst_n = 1'b0;
        #1;
        check("pulse_mem_cnt",   32'(bus_c.o_fwd_mem_cnt),  32'd0);
        check("pulse_mem_cnt_r", 32'(bus_r.o_fwd_mem_cnt),  32'd0);
        check("pulse_reg_sel_a", 32'(bus_r.o_forwarding_a), 32'h0);

        // 3-bit counter saturates at 7; 16-bit keeps counting
        @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (10) @(posedge i_clk);
        #1;
        check("sat_mem_cnt_r", 32'(bus_r.o_fwd_mem_cnt), 32'd7);
        check("sat_mem_cnt_c", 32'(bus_c.o_fwd_mem_cnt), 32'd10);

        // WB-only forwards, then MEM on A with WB on B (WB must not count)
        @(negedge i_clk);
        i_rst_n = 1'b0;
        drive(1'b0, 1'b1, 5'd4, 5'd2, 5'd3, 5'd4);
        #1;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        check("wb3_wb_cnt",  32'(bus_c.o_fwd_wb_cnt),  32'd3);
        check("wb3_mem_cnt", 32'(bus_c.o_fwd_mem_cnt), 32'd0);
        @(negedge i_clk);
        drive(1'b1, 1'b1, 5'd3, 5'd4, 5'd3, 5'd4);
        repeat (2) @(posedge i_clk);
        #1;
        check("mix_mem_cnt", 32'(bus_c.o_fwd_mem_cnt), 32'd2);
        check("mix_wb_cnt",  32'(bus_c.o_fwd_wb_cnt),  32'd3);

        // No hit: counters hold
        @(negedge i_clk);
        drive(1'b0, 1'b0, 5'd1, 5'd2, 5'd3, 5'd4);
        repeat (3) @(posedge i_clk);
        #1;
        check("idle_mem_cnt", 32'(bus_c.o_fwd_mem_cnt), 32'd2);
        check("idle_wb_cnt",  32'(bus_c.o_fwd_wb_cnt),  32'd3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
